// File: rtl/xor_stream_ctrl_if.sv
// Bundled start/config, memory-read and output-stream signals for xor_stream_ctrl.
// master = front-end/memory/consumer side, slave = the sequencer.
interface xor_stream_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  logic [7:0]        key_in;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output start, base_addr, len, key_in, mem_data, out_ready,
    input  busy, done, mem_addr, mem_rd, out_data, out_valid
  );

  modport slave (
    input  start, base_addr, len, key_in, mem_data, out_ready,
    output busy, done, mem_addr, mem_rd, out_data, out_valid
  );
endinterface

// File: rtl/xor_stream_ctrl.sv
// Byte-XOR stream sequencer: fetches len bytes from a sync memory, XORs with a key, streams out.
// Optional XOR_KEY_ROLL_EN: rotate the key left by one after every accepted byte.
module xor_stream_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [7:0]  KEY_DEFAULT = 8'h0D
) (
  input logic              clk,
  input logic              rst,
  xor_stream_ctrl_if.slave bus
);

  localparam int unsigned KEY_W = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rem;
  logic [KEY_W-1:0]  r_key;
  logic [KEY_W-1:0]  r_out_data;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_mem_rd;
  logic              r_out_valid;

  logic [2:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_rem_nxt;
  logic [KEY_W-1:0]  w_key_nxt;
  logic [KEY_W-1:0]  w_out_data_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;

  // Next-state and next-value logic; outputs are registered from the next state.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_rem_nxt      = r_rem;
    w_key_nxt      = r_key;
    w_out_data_nxt = r_out_data;
    w_mem_addr_nxt = r_mem_addr;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_addr_nxt  = bus.base_addr;
          w_rem_nxt   = bus.len;
          w_key_nxt   = (bus.key_in == KEY_W'(0)) ? KEY_DEFAULT : bus.key_in;
          w_state_nxt = (bus.len != ADDR_W'(0)) ? S_READ : S_DONE;
        end
      end
      S_READ: w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_out_data_nxt = bus.mem_data ^ r_key;
        w_addr_nxt     = r_addr + ADDR_W'(1);
        w_rem_nxt      = r_rem - ADDR_W'(1);
        w_state_nxt    = S_SEND;
      end
      S_SEND: begin
        if (bus.out_ready) begin
`ifdef XOR_KEY_ROLL_EN
          w_key_nxt = {r_key[KEY_W-2:0], r_key[KEY_W-1]};
`endif
          w_state_nxt = (r_rem == ADDR_W'(0)) ? S_DONE : S_READ;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Address is presented alongside the read strobe, both registered.
    if (w_state_nxt == S_READ) begin
      w_mem_addr_nxt = w_addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_key       <= '0;
      r_out_data  <= '0;
      r_mem_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_rem       <= w_rem_nxt;
      r_key       <= w_key_nxt;
      r_out_data  <= w_out_data_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_mem_rd    <= (w_state_nxt == S_READ);
      r_out_valid <= (w_state_nxt == S_SEND);
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_xor_stream_ctrl.sv
// Directed self-checking bench for xor_stream_ctrl with a synchronous byte-memory model.
// Expected bytes follow XOR_KEY_ROLL_EN when that macro is defined for the build.
module tb_xor_stream_ctrl;

  localparam int unsigned ADDR_W = 8;

`ifdef XOR_KEY_ROLL_EN
  localparam logic [7:0] E1 = 8'h5B;
  localparam logic [7:0] E2 = 8'h78;
  localparam logic [7:0] W1 = 8'h22;
`else
  localparam logic [7:0] E1 = 8'h4C;
  localparam logic [7:0] E2 = 8'h41;
  localparam logic [7:0] W1 = 8'h42;
`endif

  logic clk;
  logic rst;

  xor_stream_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  xor_stream_ctrl #(.ADDR_W(ADDR_W), .KEY_DEFAULT(8'h0D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] got [64];
  int n_got  = 0;
  int n_rd   = 0;
  int n_done = 0;
  int n_viol = 0;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = 8'h00;

  // Synchronous memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
  end

  // Event counters, output capture and valid/data-stability watch.
  always @(posedge clk) begin
    if (rst) begin
      pv <= 1'b0;
    end else begin
      if (bus.mem_rd) n_rd <= n_rd + 1;
      if (bus.done) n_done <= n_done + 1;
      if (bus.out_valid && bus.out_ready) begin
        got[n_got] <= bus.out_data;
        n_got      <= n_got + 1;
      end
      if (pv && !pr && (!bus.out_valid || bus.out_data != pd)) n_viol <= n_viol + 1;
      pv <= bus.out_valid;
      pr <= bus.out_ready;
      pd <= bus.out_data;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] l, input logic [7:0] k);
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.len       = l;
    bus.key_in    = k;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!bus.done && cyc < budget) begin
      tick();
      cyc++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic check_run(input string tag, input int g0, input int n,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] e [3];
    e[0] = b0; e[1] = b1; e[2] = b2;
    check({tag, "_count"}, 32'(n_got - g0), 32'(n));
    for (int i = 0; i < n && i < 3; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(got[g0 + i]), 32'(e[i]));
    end
  endtask

  int c;
  int g0;
  int r0;
  int d0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h4B; mem[8'h11] = 8'h41; mem[8'h12] = 8'h4C;
    mem[8'hFF] = 8'h61; mem[8'h00] = 8'h62;
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.key_in = '0;
    bus.out_ready = 1'b0; bus.mem_data = '0;
    tick(); tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    tick();

    // Basic decode with latency checks
    bus.out_ready = 1'b1;
    g0 = n_got; r0 = n_rd; d0 = n_done;
    do_start(8'h10, 8'd3, 8'h00);
    check("t1_busy_rise", 32'(bus.busy), 32'd1);
    check("t1_rd_t1", 32'(bus.mem_rd), 32'd1);
    check("t1_addr_t1", 32'(bus.mem_addr), 32'h10);
    tick();
    check("t1_rd_t2", 32'(bus.mem_rd), 32'd0);
    check("t1_valid_t2", 32'(bus.out_valid), 32'd0);
    tick();
    check("t1_valid_t3", 32'(bus.out_valid), 32'd1);
    check("t1_data_t3", 32'(bus.out_data), 32'h46);
    wait_done(20, c);
    check("t1_done_latency", 32'(c), 32'd7);
    check("t1_busy_in_done", 32'(bus.busy), 32'd1);
    tick();
    check("t1_done_fall", 32'(bus.done), 32'd0);
    check("t1_busy_fall", 32'(bus.busy), 32'd0);
    check_run("t1", g0, 3, 8'h46, E1, E2);
    check("t1_reads", 32'(n_rd - r0), 32'd3);
    check("t1_dones", 32'(n_done - d0), 32'd1);

    // Backpressure on byte 2
    g0 = n_got; r0 = n_rd; d0 = n_done;
    do_start(8'h10, 8'd3, 8'h00);
    repeat (4) tick();
    bus.out_ready = 1'b0;
    tick();
    check("t2_valid_hold0", 32'(bus.out_valid), 32'd1);
    check("t2_data_hold0", 32'(bus.out_data), 32'(E1));
    repeat (4) tick();
    check("t2_valid_hold4", 32'(bus.out_valid), 32'd1);
    check("t2_data_hold4", 32'(bus.out_data), 32'(E1));
    check("t2_reads_stalled", 32'(n_rd - r0), 32'd2);
    bus.out_ready = 1'b1;
    wait_done(20, c);
    tick();
    check_run("t2", g0, 3, 8'h46, E1, E2);
    check("t2_reads", 32'(n_rd - r0), 32'd3);
    check("t2_dones", 32'(n_done - d0), 32'd1);

    // Zero length
    r0 = n_rd;
    do_start(8'h10, 8'd0, 8'h00);
    check("t3_done_t1", 32'(bus.done), 32'd1);
    check("t3_rd_t1", 32'(bus.mem_rd), 32'd0);
    tick();
    check("t3_done_fall", 32'(bus.done), 32'd0);
    check("t3_busy_fall", 32'(bus.busy), 32'd0);
    check("t3_reads", 32'(n_rd - r0), 32'd0);

    // Start while busy is ignored
    g0 = n_got; d0 = n_done;
    do_start(8'h10, 8'd2, 8'h00);
    bus.start = 1'b1; bus.base_addr = 8'hFF; bus.len = 8'd5; bus.key_in = 8'h55;
    tick(); tick();
    bus.start = 1'b0;
    wait_done(20, c);
    repeat (4) tick();
    check_run("t3b", g0, 2, 8'h46, E1, 8'h00);
    check("t3b_dones", 32'(n_done - d0), 32'd1);
    check("t3b_idle", 32'(bus.busy), 32'd0);

    // Address wrap with explicit key
    g0 = n_got;
    do_start(8'hFF, 8'd2, 8'h20);
    check("t4_addr0", 32'(bus.mem_addr), 32'hFF);
    repeat (3) tick();
    check("t4_rd1", 32'(bus.mem_rd), 32'd1);
    check("t4_addr1", 32'(bus.mem_addr), 32'h00);
    wait_done(20, c);
    tick();
    check_run("t4", g0, 2, 8'h41, W1, 8'h00);

    // Reset during SEND of byte 1
    g0 = n_got; d0 = n_done;
    do_start(8'h10, 8'd3, 8'h00);
    bus.out_ready = 1'b0;
    tick(); tick();
    check("t5_in_send", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("t5_valid", 32'(bus.out_valid), 32'd0);
    check("t5_data", 32'(bus.out_data), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_done", 32'(bus.done), 32'd0);
    check("t5_rd", 32'(bus.mem_rd), 32'd0);
    check("t5_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check("t5_no_done", 32'(n_done - d0), 32'd0);
    check("t5_dropped", 32'(n_got - g0), 32'd0);
    check("t5_idle", 32'(bus.busy), 32'd0);
    g0 = n_got;
    do_start(8'h10, 8'd3, 8'h00);
    wait_done(20, c);
    tick();
    check_run("t5_rerun", g0, 3, 8'h46, E1, E2);

    check("protocol_hold", 32'(n_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
